// File: rtl/lcd_timing_pkg.sv
// lcd_timing_pkg: default 480x272 panel timing, scan states and RGB565 expansion.
package lcd_timing_pkg;
   localparam int H_ACTIVE_D = 480;
   localparam int H_FP_D     = 2;
   localparam int H_SYNC_D   = 41;
   localparam int H_BP_D     = 2;
   localparam int V_ACTIVE_D = 272;
   localparam int V_FP_D     = 2;
   localparam int V_SYNC_D   = 10;
   localparam int V_BP_D     = 2;
   typedef enum logic {ST_IDLE, ST_RUN} state_t;
   function automatic int span_total(input int act, input int fp, input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction
   localparam int H_TOTAL_D = span_total(H_ACTIVE_D, H_FP_D, H_SYNC_D, H_BP_D);
   localparam int V_TOTAL_D = span_total(V_ACTIVE_D, V_FP_D, V_SYNC_D, V_BP_D);
   // Replicating the top bits keeps full-scale 5/6-bit values at 8'hFF.
   function automatic logic [23:0] rgb565_to_888(input logic [15:0] p);
      return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
   endfunction
endpackage

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: h/v scan counters, IDLE/RUN frame FSM and raw region flags.
module lcd_timing_gen
   import lcd_timing_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_D,
   parameter int H_FP     = H_FP_D,
   parameter int H_SYNC   = H_SYNC_D,
   parameter int H_BP     = H_BP_D,
   parameter int V_ACTIVE = V_ACTIVE_D,
   parameter int V_FP     = V_FP_D,
   parameter int V_SYNC   = V_SYNC_D,
   parameter int V_BP     = V_BP_D
) (
   input  logic clk,
   input  logic reset_n,
   input  logic display_en,
   output logic active,
   output logic hsync_raw,
   output logic vsync_raw,
   output logic last_px
);
   localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int HW = $clog2(H_TOTAL);
   localparam int VW = $clog2(V_TOTAL);
   state_t state, state_nx;
   logic [HW-1:0] h, h_nx;
   logic [VW-1:0] v, v_nx;
   logic run, h_end, v_end;
   assign run   = state == ST_RUN;
   assign h_end = h == HW'(H_TOTAL - 1);
   assign v_end = v == VW'(V_TOTAL - 1);
   assign active    = run && h < HW'(H_ACTIVE) && v < VW'(V_ACTIVE);
   assign hsync_raw = run && h >= HW'(H_ACTIVE + H_FP) && h < HW'(H_ACTIVE + H_FP + H_SYNC);
   assign vsync_raw = run && v >= VW'(V_ACTIVE + V_FP) && v < VW'(V_ACTIVE + V_FP + V_SYNC);
   assign last_px   = active && h == HW'(H_ACTIVE - 1) && v == VW'(V_ACTIVE - 1);
   // display_en only matters in IDLE and on the very last clk of a frame.
   always_comb begin
      state_nx = state;
      h_nx = '0;
      v_nx = '0;
      if (state == ST_IDLE || (h_end && v_end)) state_nx = display_en ? ST_RUN : ST_IDLE;
      else begin
         h_nx = h_end ? '0 : h + 1'b1;
         v_nx = h_end ? v + 1'b1 : v;
      end
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         h <= '0;
         v <= '0;
      end else begin
         state <= state_nx;
         h <= h_nx;
         v <= v_nx;
      end
   end
endmodule

// File: rtl/lcd_frame_scanner.sv
// lcd_frame_scanner: scans the frame buffer linearly and drives RGB888 LCD timing.
module lcd_frame_scanner
   import lcd_timing_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_D,
   parameter int H_FP     = H_FP_D,
   parameter int H_SYNC   = H_SYNC_D,
   parameter int H_BP     = H_BP_D,
   parameter int V_ACTIVE = V_ACTIVE_D,
   parameter int V_FP     = V_FP_D,
   parameter int V_SYNC   = V_SYNC_D,
   parameter int V_BP     = V_BP_D,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int ADDR_W   = 20
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              display_en,
   output logic [ADDR_W-1:0] rdaddr,
   output logic              rden,
   input  logic [15:0]       rddata,
   output logic [7:0]        lcd_r,
   output logic [7:0]        lcd_g,
   output logic [7:0]        lcd_b,
   output logic              lcd_hsync,
   output logic              lcd_vsync,
   output logic              lcd_de,
   output logic              frame_done
);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
   logic hs0, vs0, last0;
   logic de1, hs1, vs1, last1, last2;
   lcd_timing_gen #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) u_timing (
      .clk(clk), .reset_n(reset_n), .display_en(display_en),
      .active(rden), .hsync_raw(hs0), .vsync_raw(vs0), .last_px(last0)
   );
   // Wrapping on the last pixel leaves the address at 0 through blanking.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rdaddr <= '0;
      else if (rden) rdaddr <= (rdaddr == LAST_ADDR) ? '0 : rdaddr + 1'b1;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         {de1, hs1, vs1, last1, last2, lcd_de, frame_done} <= 7'b0;
         lcd_hsync <= ~HS_POL;
         lcd_vsync <= ~VS_POL;
         {lcd_r, lcd_g, lcd_b} <= 24'h0;
      end else begin
         {de1, hs1, vs1, last1} <= {rden, hs0, vs0, last0};
         lcd_de <= de1;
         last2 <= last1;
         frame_done <= last2;
         lcd_hsync <= hs1 ? HS_POL : ~HS_POL;
         lcd_vsync <= vs1 ? VS_POL : ~VS_POL;
         {lcd_r, lcd_g, lcd_b} <= de1 ? rgb565_to_888(rddata) : 24'h0;
      end
   end
endmodule
